// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU operation codes and loaded-flag indices
package alu_pkg;
  localparam int N_BITS_DEFAULT = 8;
  localparam int N_OP_DEFAULT = 6;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam int LD_A = 0;
  localparam int LD_B = 1;
  localparam int LD_OP = 2;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-FF synchroniser plus counter debounce, strobes on debounced rising edge
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync;
  logic deb;
  logic [CW-1:0] cnt;
  logic done;
  assign done = (sync[1] != deb) && (cnt == LAST);
  assign o_rise = done && sync[1];
  // synchronise the raw button, then accept a new level only after it holds long enough
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync <= '0;
      deb <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], i_btn};
      if (sync[1] == deb) cnt <= '0;
      else if (done) begin
        deb <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: captures switch word into operand A/B and opcode registers on debounced presses
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEFAULT,
  parameter int N_OP = N_OP_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [N_BITS-1:0] i_sw,
  input  logic              i_btn_a,
  input  logic              i_btn_b,
  input  logic              i_btn_op,
  output logic [N_BITS-1:0] o_a,
  output logic [N_BITS-1:0] o_b,
  output logic [N_OP-1:0]   o_op,
  output logic [2:0]        o_loaded,
  output logic              o_ready
);
  logic [N_BITS-1:0] sw_meta, sw_sync;
  logic [2:0] rise;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_a), .o_rise(rise[LD_A])
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_b), .o_rise(rise[LD_B])
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(i_btn_op), .o_rise(rise[LD_OP])
  );
  // switches are held static before a press, so a bus-wide 2-FF stage is enough
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= i_sw;
      sw_sync <= sw_meta;
    end
  end
  // each register loads on its debounced rising edge; flags are sticky until reset
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_a <= '0;
      o_b <= '0;
      o_op <= '0;
      o_loaded <= '0;
    end else begin
      if (rise[LD_A]) o_a <= sw_sync;
      if (rise[LD_B]) o_b <= sw_sync;
      if (rise[LD_OP]) o_op <= sw_sync[N_OP-1:0];
      o_loaded <= o_loaded | rise;
    end
  end
  assign o_ready = &o_loaded;
endmodule

// File: tb/tb_alu_operand_loader.sv
// tb_alu_operand_loader: directed checks of load latency, hold, bounce, simultaneous press and reset
module tb_alu_operand_loader;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] sw;
  logic btn_a, btn_b, btn_op;
  logic [7:0] a, b;
  logic [5:0] op;
  logic [2:0] loaded;
  logic ready;
  int checks = 0;
  int errors = 0;

  alu_operand_loader #(.N_BITS(8), .N_OP(6), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_sw(sw), .i_btn_a(btn_a), .i_btn_b(btn_b),
    .i_btn_op(btn_op), .o_a(a), .o_b(b), .o_op(op), .o_loaded(loaded), .o_ready(ready)
  );

  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] which);
    @(negedge clk);
    {btn_op, btn_b, btn_a} = which;
    cycles(10);
    @(negedge clk);
    {btn_op, btn_b, btn_a} = 3'b000;
    cycles(10);
  endtask

  task automatic test_reset;
    checks++;
    if ({a, b, op, loaded, ready} !== 26'd0) begin
      errors++;
      $display("FAIL reset_state got a=%h b=%h op=%h loaded=%b ready=%b want all 0", a, b, op, loaded, ready);
    end
  endtask

  task automatic test_load_a;
    @(negedge clk);
    sw = 8'h3C;
    cycles(4);
    @(negedge clk);
    btn_a = 1'b1;
    cycles(5);
    checks++;
    if (a !== 8'h00) begin
      errors++;
      $display("FAIL load_a_early got %h want 00", a);
    end
    cycles(1);
    checks++;
    if (a !== 8'h3C || loaded !== 3'b001) begin
      errors++;
      $display("FAIL load_a_edge6 got a=%h loaded=%b want 3c 001", a, loaded);
    end
    checks++;
    if (b !== 8'h00 || op !== 6'h00 || ready !== 1'b0) begin
      errors++;
      $display("FAIL load_a_others got b=%h op=%h ready=%b want 00 00 0", b, op, ready);
    end
    @(negedge clk);
    sw = 8'hFF;
    cycles(8);
    checks++;
    if (a !== 8'h3C) begin
      errors++;
      $display("FAIL load_a_hold got %h want 3c", a);
    end
    @(negedge clk);
    btn_a = 1'b0;
    cycles(10);
    checks++;
    if (a !== 8'h3C || loaded !== 3'b001) begin
      errors++;
      $display("FAIL load_a_release got a=%h loaded=%b want 3c 001", a, loaded);
    end
  endtask

  task automatic test_bounce_b;
    logic [6:0] pattern;
    pattern = 7'b1110110;
    @(negedge clk);
    sw = 8'h77;
    cycles(4);
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      btn_b = pattern[i];
    end
    @(negedge clk);
    btn_b = 1'b0;
    cycles(12);
    checks++;
    if (b !== 8'h00 || loaded[1] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_b got b=%h loaded=%b want 00 x0x", b, loaded);
    end
  endtask

  task automatic test_simultaneous;
    @(negedge clk);
    sw = 8'hA5;
    cycles(4);
    @(negedge clk);
    {btn_b, btn_a} = 2'b11;
    cycles(5);
    checks++;
    if (a !== 8'h3C || b !== 8'h00) begin
      errors++;
      $display("FAIL simul_early got a=%h b=%h want 3c 00", a, b);
    end
    cycles(1);
    checks++;
    if (a !== 8'hA5 || b !== 8'hA5 || loaded !== 3'b011 || ready !== 1'b0) begin
      errors++;
      $display("FAIL simul_edge got a=%h b=%h loaded=%b ready=%b want a5 a5 011 0", a, b, loaded, ready);
    end
    @(negedge clk);
    {btn_b, btn_a} = 2'b00;
    cycles(10);
  endtask

  task automatic test_full_sequence;
    @(negedge clk);
    sw = 8'h05;
    cycles(4);
    press(3'b001);
    @(negedge clk);
    sw = 8'h0A;
    cycles(4);
    press(3'b010);
    @(negedge clk);
    sw = 8'h20;
    cycles(4);
    press(3'b100);
    checks++;
    if (a !== 8'h05 || b !== 8'h0A || op !== 6'b100000) begin
      errors++;
      $display("FAIL full_regs got a=%h b=%h op=%b want 05 0a 100000", a, b, op);
    end
    checks++;
    if (loaded !== 3'b111 || ready !== 1'b1) begin
      errors++;
      $display("FAIL full_flags got loaded=%b ready=%b want 111 1", loaded, ready);
    end
    checks++;
    if (8'(a + b) !== 8'h0F) begin
      errors++;
      $display("FAIL full_sum got %h want 0f", 8'(a + b));
    end
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({a, b, op, loaded, ready} !== 26'd0) begin
      errors++;
      $display("FAIL async_reset got a=%h b=%h op=%h loaded=%b ready=%b want all 0", a, b, op, loaded, ready);
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_reset_mid_op;
    @(negedge clk);
    sw = 8'hE7;
    cycles(4);
    @(negedge clk);
    btn_op = 1'b1;
    cycles(4);
    rst = 1'b1;
    #1;
    checks++;
    if (op !== 6'h00 || loaded !== 3'b000) begin
      errors++;
      $display("FAIL midop_reset got op=%h loaded=%b want 00 000", op, loaded);
    end
    @(negedge clk);
    rst = 1'b0;
    cycles(5);
    checks++;
    if (op !== 6'h00 || loaded !== 3'b000) begin
      errors++;
      $display("FAIL midop_early got op=%h loaded=%b want 00 000", op, loaded);
    end
    cycles(1);
    checks++;
    if (op !== 6'h27 || loaded !== 3'b100 || ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_load got op=%h loaded=%b ready=%b want 27 100 0", op, loaded, ready);
    end
    @(negedge clk);
    btn_op = 1'b0;
    cycles(10);
  endtask

  initial begin
    rst = 1'b1;
    sw = 8'h00;
    {btn_a, btn_b, btn_op} = 3'b000;
    cycles(3);
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    cycles(2);
    test_load_a;
    test_bounce_b;
    test_simultaneous;
    test_full_sequence;
    test_async_reset;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
